addsub_acc_ctrl: RTL and testbench
==================================

Name: addsub_acc_ctrl

Overview:
Sequencing/accumulator stage wrapped around the 4-bit ripple add/subtract unit. It accepts commands over a valid/ready handshake, drives the unit's mode and operand inputs, and holds them for a settle window. It then captures the unit's sum and carry-out into a 4-bit accumulator with status flags, and presents the result downstream on a valid/ready handshake.

Parameters:
SETTLE_CYCLES, 1, cycles the adder inputs are held stable in EXEC before the sum is captured; legal range 1..15.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command; high only in IDLE
cmd_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
cmd_data  input  4  operand (LOAD value, or ADD/SUB y operand)
add_m  output  1  mode to adder: 0 add, 1 subtract
add_x  output  4  adder x operand; always equals acc
add_y  output  4  adder y operand; registered copy of cmd_data
add_s  input  4  adder sum
add_cout  input  1  adder carry-out
acc  output  4  accumulator value
flag_c  output  1  carry: ADD carry-out; SUB 1 = no borrow (x >= y unsigned)
flag_z  output  1  acc == 0
flag_n  output  1  acc[3]
flag_v  output  1  signed overflow of last ADD/SUB
res_valid  output  1  result and flags valid
res_ready  input  1  downstream accepts result

Behaviour:
- Reset (rst_n low at an edge) forces, from any state including mid-EXEC: state IDLE, acc=0, add_y=0, add_m=0, flags c/n/v=0, flag_z=1, res_valid=0, settle counter=0.
- States: IDLE, EXEC, DONE.
- IDLE: cmd_ready=1. Acceptance is cmd_valid & cmd_ready at an edge.
  - LOAD: acc<=cmd_data. Go to DONE.
  - CLEAR: acc<=0. Go to DONE.
  - ADD/SUB: add_y<=cmd_data, add_m<=cmd_op[1]. Go to EXEC with counter=0.
  - Otherwise stay in IDLE.
- EXEC: cmd_ready=0. add_m, add_x and add_y stay constant throughout.
  - The counter increments each cycle.
  - On the edge where counter==SETTLE_CYCLES-1: acc<=add_s and flags update. Go to DONE.
  - ADD/SUB latency from acceptance edge to res_valid high: SETTLE_CYCLES+1 edges.
- DONE: res_valid=1, cmd_ready=0. Outputs hold stable while res_ready=0.
  - On an edge with res_ready=1: go to IDLE, res_valid=0.
  - A command presented during DONE is accepted no earlier than the first IDLE cycle. There is no bypass.
- Flag update on ADD/SUB capture:
  - flag_c = add_cout.
  - flag_v = (x[3] == (y[3]^m)) & (add_s[3] != x[3]).
  - z/n computed from the new acc.
- Flag update on LOAD/CLEAR: c=0, v=0, z/n from the new acc.
- Flags and acc change only at capture, LOAD or CLEAR. They are never updated combinationally from add_s.
- Wrap-around is modulo 16 unless the optional feature is enabled.
- add_x mirrors acc combinationally. add_m and add_y retain their last values outside EXEC.

Optional Feature:
ADDSUB_SAT_EN
- Defined: on ADD/SUB capture with computed overflow, acc<=0111 if x[3]=0, or acc<=1000 if x[3]=1. flag_v=1 still reports the overflow; flag_c = add_cout unchanged.
- Undefined: acc<=add_s unconditionally (two's-complement wrap).

Test Plan:
- LOAD 0101, then ADD 0011 (SETTLE_CYCLES=1) -> res_valid 2 edges after acceptance.
  - Without sat: acc=1000, c=0, z=0, n=1, v=1.
  - With ADDSUB_SAT_EN: acc=0111, n=0, v=1.
- LOAD 0101, then SUB 0011 -> acc=0010, add_m=1 during EXEC, c=1, z=0, n=0, v=0.
- LOAD 1111, then ADD 0001 -> acc=0000, c=1, z=1, n=0, v=0; cmd_ready=0 from acceptance until the cycle after the res_ready handshake.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid with cmd_valid=1 (LOAD 1010) -> acc/flags stable, cmd_ready=0; release -> LOAD accepted in the next IDLE cycle, acc=1010, n=1.
- Reset mid-op: SETTLE_CYCLES=4, assert rst_n=0 at the 2nd EXEC cycle -> next edge: state IDLE, acc=0, flag_z=1, res_valid=0, cmd_ready=1; no capture of add_s.
- CLEAR after a SUB with borrow (LOAD 0011, SUB 0101 -> acc=1110, c=0, n=1) -> acc=0000, c=0, v=0, z=1.

Source files
------------

// File: rtl/addsub_acc_ctrl_if.sv
// Command and result handshake bundle for addsub_acc_ctrl.
// The master side issues commands and consumes results; the slave side is the controller.
interface addsub_acc_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_data;
  logic       res_valid;
  logic       res_ready;
  logic [3:0] acc;
  logic       flag_c;
  logic       flag_z;
  logic       flag_n;
  logic       flag_v;

  modport master (
    output cmd_valid, cmd_op, cmd_data, res_ready,
    input  cmd_ready, res_valid, acc, flag_c, flag_z, flag_n, flag_v
  );
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, res_ready,
    output cmd_ready, res_valid, acc, flag_c, flag_z, flag_n, flag_v
  );
endinterface

// File: rtl/addsub_acc_ctrl.sv
// Command sequencer and 4-bit accumulator around an external ripple add/subtract unit.
// Define ADDSUB_SAT_EN to saturate the accumulator on signed overflow instead of wrapping.
module addsub_acc_ctrl #(
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  addsub_acc_ctrl_if.slave    bus,
  output logic                add_m,
  output logic [3:0]          add_x,
  output logic [3:0]          add_y,
  input  logic [3:0]          add_s,
  input  logic                add_cout
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] cnt;
  logic [3:0] acc_q;
  logic       c_q;
  logic       v_q;
  logic       ovf;
  logic [3:0] acc_next;

  // Signed overflow: operands share a sign (after subtract inversion) but the sum does not.
  assign ovf = (add_x[3] == (add_y[3] ^ add_m)) & (add_s[3] != add_x[3]);

`ifdef ADDSUB_SAT_EN
  assign acc_next = ovf ? (add_x[3] ? 4'b1000 : 4'b0111) : add_s;
`else
  assign acc_next = add_s;
`endif

  assign add_x         = acc_q;
  assign bus.acc       = acc_q;
  assign bus.flag_c    = c_q;
  assign bus.flag_v    = v_q;
  assign bus.flag_z    = (acc_q == 4'd0);
  assign bus.flag_n    = acc_q[3];
  assign bus.cmd_ready = (state == IDLE);
  assign bus.res_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      acc_q <= 4'd0;
      c_q   <= 1'b0;
      v_q   <= 1'b0;
      add_y <= 4'd0;
      add_m <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_op)
              OP_LOAD: begin
                acc_q <= bus.cmd_data;
                c_q   <= 1'b0;
                v_q   <= 1'b0;
                state <= DONE;
              end
              OP_CLEAR: begin
                acc_q <= 4'd0;
                c_q   <= 1'b0;
                v_q   <= 1'b0;
                state <= DONE;
              end
              default: begin
                add_y <= bus.cmd_data;
                add_m <= bus.cmd_op[1];
                cnt   <= 4'd0;
                state <= EXEC;
              end
            endcase
          end
        end
        EXEC: begin
          cnt <= cnt + 4'd1;
          // Adder inputs have been stable for the whole window; take the sum.
          if (cnt == LAST) begin
            acc_q <= acc_next;
            c_q   <= add_cout;
            v_q   <= ovf;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_acc_ctrl.sv
// Directed bench for addsub_acc_ctrl: two instances (settle 1 and 4) each driving a behavioural adder.
module tb_addsub_acc_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst4_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  addsub_acc_ctrl_if if1 ();
  addsub_acc_ctrl_if if4 ();

  logic       m1, m4, co1, co4;
  logic [3:0] x1, y1, s1, x4, y4, s4;

  // Reference ripple add/subtract unit: s = x + (y ^ m) + m.
  assign {co1, s1} = {1'b0, x1} + {1'b0, y1 ^ {4{m1}}} + {4'd0, m1};
  assign {co4, s4} = {1'b0, x4} + {1'b0, y4 ^ {4{m4}}} + {4'd0, m4};

  addsub_acc_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .add_m(m1), .add_x(x1), .add_y(y1), .add_s(s1), .add_cout(co1)
  );
  addsub_acc_ctrl #(.SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .rst_n(rst4_n), .bus(if4.slave),
    .add_m(m4), .add_x(x4), .add_y(y4), .add_s(s4), .add_cout(co4)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on dut1 (waits for cmd_ready with a bound).
  task automatic send1(input logic [1:0] op, input logic [3:0] d);
    int n = 0;
    while (!if1.cmd_ready && n < 20) begin step(); n++; end
    tests++;
    if (!if1.cmd_ready) begin fails++; $display("FAIL send1_ready timeout got %b exp 1", if1.cmd_ready); end
    if1.cmd_valid = 1'b1; if1.cmd_op = op; if1.cmd_data = d;
    step();
    if1.cmd_valid = 1'b0;
  endtask

  task automatic wait_res1();
    int n = 0;
    while (!if1.res_valid && n < 20) begin step(); n++; end
    tests++;
    if (!if1.res_valid) begin fails++; $display("FAIL wait_res1 timeout got %b exp 1", if1.res_valid); end
  endtask

  task automatic ack1();
    if1.res_ready = 1'b1;
    step();
    if1.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst4_n = 1'b0;
    step(); step();
    tests++;
    if ({if1.cmd_ready, if1.res_valid, if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v} !== 10'b1_0_0000_0100) begin
      fails++;
      $display("FAIL reset_state got rdy=%b vld=%b acc=%h czn v=%b%b%b%b exp rdy=1 vld=0 acc=0 cznv=0100",
               if1.cmd_ready, if1.res_valid, if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v);
    end
    tests++;
    if ({m1, y1, x1} !== 9'd0) begin fails++; $display("FAIL reset_adder_ins got m=%b y=%h x=%h exp 0", m1, y1, x1); end
    rst_n = 1'b1; rst4_n = 1'b1;
    step();
  endtask

  task automatic test_add_overflow();
    send1(2'b00, 4'b0101); ack1();
    send1(2'b01, 4'b0011);
    tests++;
    if ({if1.res_valid, if1.cmd_ready} !== 2'b00) begin fails++; $display("FAIL add_latency_early got vld=%b rdy=%b exp 00", if1.res_valid, if1.cmd_ready); end
    step();
    tests++;
    if (if1.res_valid !== 1'b1) begin fails++; $display("FAIL add_latency got vld=%b exp 1", if1.res_valid); end
`ifdef ADDSUB_SAT_EN
    tests++;
    if ({if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v} !== 8'b0111_0001) begin
      fails++; $display("FAIL add_sat got acc=%b cznv=%b%b%b%b exp acc=0111 cznv=0001", if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v);
    end
`else
    tests++;
    if ({if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v} !== 8'b1000_0011) begin
      fails++; $display("FAIL add_wrap got acc=%b cznv=%b%b%b%b exp acc=1000 cznv=0011", if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v);
    end
`endif
    ack1();
  endtask

  task automatic test_sub();
    send1(2'b00, 4'b0101); ack1();
    send1(2'b10, 4'b0011);
    tests++;
    if ({m1, y1, x1} !== 9'b1_0011_0101) begin fails++; $display("FAIL sub_exec_ins got m=%b y=%b x=%b exp m=1 y=0011 x=0101", m1, y1, x1); end
    wait_res1();
    tests++;
    if ({if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v} !== 8'b0010_1000) begin
      fails++; $display("FAIL sub_result got acc=%b cznv=%b%b%b%b exp acc=0010 cznv=1000", if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v);
    end
    ack1();
  endtask

  task automatic test_carry_zero();
    send1(2'b00, 4'b1111); ack1();
    send1(2'b01, 4'b0001);
    tests++;
    if (if1.cmd_ready !== 1'b0) begin fails++; $display("FAIL cz_ready_exec got %b exp 0", if1.cmd_ready); end
    wait_res1();
    tests++;
    if ({if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v, if1.cmd_ready} !== 9'b0000_1100_0) begin
      fails++; $display("FAIL cz_result got acc=%b cznv=%b%b%b%b rdy=%b exp acc=0000 cznv=1100 rdy=0",
                        if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v, if1.cmd_ready);
    end
    ack1();
    tests++;
    if ({if1.cmd_ready, if1.res_valid} !== 2'b10) begin fails++; $display("FAIL cz_after_ack got rdy=%b vld=%b exp 10", if1.cmd_ready, if1.res_valid); end
  endtask

  task automatic test_backpressure();
    send1(2'b00, 4'b0110);
    if1.cmd_valid = 1'b1; if1.cmd_op = 2'b00; if1.cmd_data = 4'b1010;
    for (int i = 0; i < 5; i++) begin
      step();
      tests++;
      if ({if1.res_valid, if1.cmd_ready, if1.acc, if1.flag_z, if1.flag_n} !== 8'b1_0_0110_00) begin
        fails++; $display("FAIL bp_hold%0d got vld=%b rdy=%b acc=%b z=%b n=%b exp vld=1 rdy=0 acc=0110 z=0 n=0",
                          i, if1.res_valid, if1.cmd_ready, if1.acc, if1.flag_z, if1.flag_n);
      end
    end
    if1.res_ready = 1'b1;
    step();
    if1.res_ready = 1'b0;
    tests++;
    if ({if1.cmd_ready, if1.res_valid, if1.acc} !== 6'b1_0_0110) begin
      fails++; $display("FAIL bp_no_bypass got rdy=%b vld=%b acc=%b exp rdy=1 vld=0 acc=0110", if1.cmd_ready, if1.res_valid, if1.acc);
    end
    step();
    if1.cmd_valid = 1'b0;
    tests++;
    if ({if1.res_valid, if1.acc, if1.flag_n, if1.flag_c, if1.flag_v} !== 8'b1_1010_100) begin
      fails++; $display("FAIL bp_load got vld=%b acc=%b n=%b c=%b v=%b exp vld=1 acc=1010 n=1 c=0 v=0",
                        if1.res_valid, if1.acc, if1.flag_n, if1.flag_c, if1.flag_v);
    end
    ack1();
  endtask

  task automatic test_reset_mid_op();
    if4.cmd_valid = 1'b1; if4.cmd_op = 2'b00; if4.cmd_data = 4'b0101;
    step();
    if4.cmd_valid = 1'b0; if4.res_ready = 1'b1;
    step();
    if4.res_ready = 1'b0;
    if4.cmd_valid = 1'b1; if4.cmd_op = 2'b01; if4.cmd_data = 4'b0011;
    step();
    if4.cmd_valid = 1'b0;
    tests++;
    if ({if4.cmd_ready, if4.acc} !== 5'b0_0101) begin fails++; $display("FAIL rst_exec_entry got rdy=%b acc=%b exp rdy=0 acc=0101", if4.cmd_ready, if4.acc); end
    step();
    rst4_n = 1'b0;
    step();
    rst4_n = 1'b1;
    tests++;
    if ({if4.cmd_ready, if4.res_valid, if4.acc, if4.flag_z, if4.flag_c, if4.flag_n, if4.flag_v, m4, y4} !== 17'b1_0_0000_1000_0_0000) begin
      fails++; $display("FAIL rst_mid_op got rdy=%b vld=%b acc=%b zcnv=%b%b%b%b m=%b y=%b exp rdy=1 vld=0 acc=0 zcnv=1000 m=0 y=0",
                        if4.cmd_ready, if4.res_valid, if4.acc, if4.flag_z, if4.flag_c, if4.flag_n, if4.flag_v, m4, y4);
    end
    for (int i = 0; i < 5; i++) step();
    tests++;
    if ({if4.res_valid, if4.acc} !== 5'b0_0000) begin fails++; $display("FAIL rst_no_capture got vld=%b acc=%b exp vld=0 acc=0000", if4.res_valid, if4.acc); end
  endtask

  task automatic test_clear_after_borrow();
    send1(2'b00, 4'b0011); ack1();
    send1(2'b10, 4'b0101);
    wait_res1();
    tests++;
    if ({if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v} !== 8'b1110_0010) begin
      fails++; $display("FAIL borrow_result got acc=%b cznv=%b%b%b%b exp acc=1110 cznv=0010", if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v);
    end
    ack1();
    send1(2'b11, 4'b1001);
    tests++;
    if ({if1.res_valid, if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v} !== 9'b1_0000_0100) begin
      fails++; $display("FAIL clear_result got vld=%b acc=%b cznv=%b%b%b%b exp vld=1 acc=0000 cznv=0100",
                        if1.res_valid, if1.acc, if1.flag_c, if1.flag_z, if1.flag_n, if1.flag_v);
    end
    ack1();
  endtask

  initial begin
    if1.cmd_valid = 1'b0; if1.cmd_op = 2'b00; if1.cmd_data = 4'd0; if1.res_ready = 1'b0;
    if4.cmd_valid = 1'b0; if4.cmd_op = 2'b00; if4.cmd_data = 4'd0; if4.res_ready = 1'b0;
    test_reset();
    test_add_overflow();
    test_sub();
    test_carry_zero();
    test_backpressure();
    test_reset_mid_op();
    test_clear_after_borrow();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
